// File: rtl/fft4_if.sv
// Streaming handshake bundle for the 4-point FFT sequencer.
// The slave side is the FFT block and the master side is the producer/consumer.
interface fft4_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_index;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_index
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_index
  );
endinterface

// File: rtl/fft4_sequencer.sv
// Serial-in/serial-out 4-point radix-2 DIT FFT on packed complex nibbles.
// Frames are loaded, butterflied in two registered stages, then unloaded X0..X3.
module fft4_sequencer #(
  parameter bit SAT = 1'b0
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   flush,
  fft4_if.slave  bus,
  output logic   busy,
  output logic   frame_done
);

  typedef enum logic [1:0] {LOAD, STAGE1, STAGE2, UNLOAD} state_t;

  state_t     state_reg;
  logic [1:0] n_reg;
  logic [1:0] k_reg;
  logic [7:0] x_reg [4];
  logic [7:0] e0_reg, e1_reg, o0_reg, o1_reg;
  logic [7:0] bin_reg [4];
  logic       in_ready_reg;
  logic       out_valid_reg;
  logic       frame_done_reg;
  logic [7:0] out_data_reg;
  logic [1:0] out_index_reg;

  logic [7:0] e0_next, e1_next, o0_next, o1_next;
  logic [7:0] bin_next [4];

  // Signed nibble add/subtract with either wrap-around or clamping to [-8,+7].
  function automatic logic [3:0] nib_op(input logic [3:0] a, input logic [3:0] b,
                                        input logic sub);
    logic signed [4:0] s;
    s = sub ? ($signed({a[3], a}) - $signed({b[3], b}))
            : ($signed({a[3], a}) + $signed({b[3], b}));
    if (SAT && (s > 5'sd7))
      return 4'b0111;
    if (SAT && (s < -5'sd8))
      return 4'b1000;
    return s[3:0];
  endfunction

  // Lane 1 is the real nibble [7:4], lane 0 the imaginary nibble [3:0].
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      assign e0_next[gi*4 +: 4]     = nib_op(x_reg[0][gi*4 +: 4], x_reg[2][gi*4 +: 4], 1'b0);
      assign e1_next[gi*4 +: 4]     = nib_op(x_reg[0][gi*4 +: 4], x_reg[2][gi*4 +: 4], 1'b1);
      assign o0_next[gi*4 +: 4]     = nib_op(x_reg[1][gi*4 +: 4], x_reg[3][gi*4 +: 4], 1'b0);
      assign o1_next[gi*4 +: 4]     = nib_op(x_reg[1][gi*4 +: 4], x_reg[3][gi*4 +: 4], 1'b1);
      assign bin_next[0][gi*4 +: 4] = nib_op(e0_reg[gi*4 +: 4], o0_reg[gi*4 +: 4], 1'b0);
      assign bin_next[2][gi*4 +: 4] = nib_op(e0_reg[gi*4 +: 4], o0_reg[gi*4 +: 4], 1'b1);
    end
  endgenerate

  // Odd bins use the -j twiddle, which swaps real and imaginary parts of O1.
  assign bin_next[1][7:4] = nib_op(e1_reg[7:4], o1_reg[3:0], 1'b0);
  assign bin_next[1][3:0] = nib_op(e1_reg[3:0], o1_reg[7:4], 1'b1);
  assign bin_next[3][7:4] = nib_op(e1_reg[7:4], o1_reg[3:0], 1'b1);
  assign bin_next[3][3:0] = nib_op(e1_reg[3:0], o1_reg[7:4], 1'b0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= LOAD;
      n_reg          <= 2'd0;
      k_reg          <= 2'd0;
      e0_reg         <= 8'd0;
      e1_reg         <= 8'd0;
      o0_reg         <= 8'd0;
      o1_reg         <= 8'd0;
      in_ready_reg   <= 1'b1;
      out_valid_reg  <= 1'b0;
      frame_done_reg <= 1'b0;
      out_data_reg   <= 8'd0;
      out_index_reg  <= 2'd0;
      for (int i = 0; i < 4; i++) begin
        x_reg[i]   <= 8'd0;
        bin_reg[i] <= 8'd0;
      end
    end else if (flush) begin
      // Abort wins over any handshake seen on the same edge.
      state_reg      <= LOAD;
      n_reg          <= 2'd0;
      k_reg          <= 2'd0;
      in_ready_reg   <= 1'b1;
      out_valid_reg  <= 1'b0;
      frame_done_reg <= 1'b0;
      out_data_reg   <= 8'd0;
      out_index_reg  <= 2'd0;
    end else begin
      frame_done_reg <= 1'b0;
      case (state_reg)
        LOAD: begin
          if (bus.in_valid && in_ready_reg) begin
            x_reg[n_reg] <= bus.in_data;
            n_reg        <= n_reg + 2'd1;
            if (n_reg == 2'd3) begin
              state_reg    <= STAGE1;
              in_ready_reg <= 1'b0;
            end
          end
        end
        STAGE1: begin
          e0_reg    <= e0_next;
          e1_reg    <= e1_next;
          o0_reg    <= o0_next;
          o1_reg    <= o1_next;
          state_reg <= STAGE2;
        end
        STAGE2: begin
          for (int i = 0; i < 4; i++)
            bin_reg[i] <= bin_next[i];
          out_data_reg  <= bin_next[0];
          out_index_reg <= 2'd0;
          out_valid_reg <= 1'b1;
          k_reg         <= 2'd0;
          state_reg     <= UNLOAD;
        end
        UNLOAD: begin
          if (bus.out_ready) begin
            if (k_reg == 2'd3) begin
              state_reg      <= LOAD;
              k_reg          <= 2'd0;
              n_reg          <= 2'd0;
              in_ready_reg   <= 1'b1;
              out_valid_reg  <= 1'b0;
              out_data_reg   <= 8'd0;
              out_index_reg  <= 2'd0;
              frame_done_reg <= 1'b1;
            end else begin
              k_reg         <= k_reg + 2'd1;
              out_data_reg  <= bin_reg[k_reg + 2'd1];
              out_index_reg <= k_reg + 2'd1;
            end
          end
        end
        default: state_reg <= LOAD;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.out_index = out_index_reg;
  assign frame_done    = frame_done_reg;
  assign busy          = (state_reg != LOAD) || (n_reg != 2'd0);

endmodule

// File: tb/tb_fft4_sequencer.sv
// Directed bench for fft4_sequencer: wrap and saturating instances run in lockstep
// on a table of frames, plus backpressure, flush and async-reset sequences.
module tb_fft4_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  logic busy_w, busy_s, done_w, done_s;
  int   checks = 0;
  int   failures = 0;
  int   done_count;

  fft4_if if_w ();
  fft4_if if_s ();

  fft4_sequencer #(.SAT(1'b0)) dut_w (
    .clk(clk), .rst(rst), .flush(flush), .bus(if_w.slave),
    .busy(busy_w), .frame_done(done_w)
  );

  fft4_sequencer #(.SAT(1'b1)) dut_s (
    .clk(clk), .rst(rst), .flush(flush), .bus(if_s.slave),
    .busy(busy_s), .frame_done(done_s)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] x;   // x0 in [31:24] .. x3 in [7:0]
    logic [31:0] ew;  // expected bins X0..X3, wrap mode
    logic [31:0] es;  // expected bins X0..X3, saturating mode
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%02h expected=%02h", nm, act, exp);
    end
  endtask

  task automatic drive_in(input logic v, input logic [7:0] d);
    if_w.in_valid = v; if_w.in_data = d;
    if_s.in_valid = v; if_s.in_data = d;
  endtask

  task automatic set_ready(input logic r);
    if_w.out_ready = r;
    if_s.out_ready = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Feeds four samples back to back; returns one cycle after x3 is accepted.
  task automatic load4(input logic [31:0] x);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("in_ready_w[%0d]", i), {7'd0, if_w.in_ready}, 8'd1);
      chk($sformatf("in_ready_s[%0d]", i), {7'd0, if_s.in_ready}, 8'd1);
      drive_in(1'b1, x[31-8*i -: 8]);
      tick();
    end
    drive_in(1'b0, 8'h00);
  endtask

  task automatic send_frame(input logic [31:0] x);
    load4(x);
    chk("stage1_in_ready", {7'd0, if_w.in_ready}, 8'd0);
    chk("stage1_out_valid", {7'd0, if_w.out_valid}, 8'd0);
    tick();
    chk("stage2_out_valid", {7'd0, if_w.out_valid}, 8'd0);
    chk("stage2_busy", {7'd0, busy_w}, 8'd1);
    tick();
    chk("latency_out_valid_w", {7'd0, if_w.out_valid}, 8'd1);
    chk("latency_out_valid_s", {7'd0, if_s.out_valid}, 8'd1);
  endtask

  // Drains the four bins; stall_k selects a bin held with out_ready low for 3 cycles.
  task automatic unload(input logic [31:0] ew, input logic [31:0] es, input int stall_k);
    done_count = 0;
    set_ready(1'b1);
    for (int k = 0; k < 4; k++) begin
      if (k == stall_k) begin
        set_ready(1'b0);
        for (int s = 0; s < 3; s++) begin
          tick();
          chk($sformatf("stall_data[%0d]", s), if_w.out_data, ew[31-8*k -: 8]);
          chk($sformatf("stall_index[%0d]", s), {6'd0, if_w.out_index}, k[7:0]);
          chk($sformatf("stall_in_ready[%0d]", s), {7'd0, if_w.in_ready}, 8'd0);
          if (done_w) done_count++;
        end
        set_ready(1'b1);
      end
      chk($sformatf("out_valid_w[%0d]", k), {7'd0, if_w.out_valid}, 8'd1);
      chk($sformatf("bin_w[%0d]", k), if_w.out_data, ew[31-8*k -: 8]);
      chk($sformatf("bin_s[%0d]", k), if_s.out_data, es[31-8*k -: 8]);
      chk($sformatf("index_w[%0d]", k), {6'd0, if_w.out_index}, k[7:0]);
      chk($sformatf("index_s[%0d]", k), {6'd0, if_s.out_index}, k[7:0]);
      if (done_w) done_count++;
      tick();
    end
    chk("frame_done_w", {7'd0, done_w}, 8'd1);
    chk("frame_done_s", {7'd0, done_s}, 8'd1);
    chk("post_out_valid", {7'd0, if_w.out_valid}, 8'd0);
    chk("post_out_data", if_w.out_data, 8'h00);
    chk("post_busy", {7'd0, busy_w}, 8'd0);
    chk("post_in_ready", {7'd0, if_w.in_ready}, 8'd1);
    tick();
    chk("frame_done_pulse_end", {7'd0, done_w}, 8'd0);
    chk("frame_done_early", done_count[7:0], 8'd0);
  endtask

  initial begin
    vecs[0] = '{x: 32'h10000000, ew: 32'h10101010, es: 32'h10101010};
    vecs[1] = '{x: 32'h00100000, ew: 32'h100FF001, es: 32'h100FF001};
    vecs[2] = '{x: 32'h70707070, ew: 32'hC0000000, es: 32'h70000000};
    vecs[3] = '{x: 32'h01010101, ew: 32'h04000000, es: 32'h04000000};
    vecs[4] = '{x: 32'h88888888, ew: 32'h00000000, es: 32'h88000000};
    vecs[5] = '{x: 32'h10203040, ew: 32'hA0E2E0EE, es: 32'h70E2E0EE};

    drive_in(1'b0, 8'h00);
    set_ready(1'b1);

    // Reset values are visible before any clock edge.
    #1 rst = 1'b1;
    #1;
    chk("rst_in_ready", {7'd0, if_w.in_ready}, 8'd1);
    chk("rst_out_valid", {7'd0, if_w.out_valid}, 8'd0);
    chk("rst_out_data", if_w.out_data, 8'h00);
    chk("rst_out_index", {6'd0, if_w.out_index}, 8'd0);
    chk("rst_busy", {7'd0, busy_w}, 8'd0);
    chk("rst_frame_done", {7'd0, done_w}, 8'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    for (int v = 0; v < 6; v++) begin
      send_frame(vecs[v].x);
      unload(vecs[v].ew, vecs[v].es, -1);
      $display("vector %0d x=%08h checked (checks=%0d failures=%0d)", v, vecs[v].x, checks, failures);
    end

    // Backpressure on X1 of the shifted impulse.
    send_frame(32'h00100000);
    unload(32'h100FF001, 32'h100FF001, 1);
    $display("backpressure sequence checked (checks=%0d failures=%0d)", checks, failures);

    // Abort after two samples; the flush edge also carries a valid sample that must be dropped.
    drive_in(1'b1, 8'h70); tick();
    drive_in(1'b1, 8'h70); tick();
    chk("abort_busy_before", {7'd0, busy_w}, 8'd1);
    drive_in(1'b1, 8'h55);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive_in(1'b0, 8'h00);
    chk("abort_busy_after", {7'd0, busy_w}, 8'd0);
    send_frame(32'h10000000);
    unload(32'h10101010, 32'h10101010, -1);
    $display("abort-in-load sequence checked (checks=%0d failures=%0d)", checks, failures);

    // Flush during UNLOAD with out_ready high: no transfer counted, no frame_done.
    send_frame(32'h10000000);
    set_ready(1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("uflush_out_valid", {7'd0, if_w.out_valid}, 8'd0);
    chk("uflush_out_data", if_w.out_data, 8'h00);
    chk("uflush_frame_done", {7'd0, done_w}, 8'd0);
    chk("uflush_busy", {7'd0, busy_w}, 8'd0);
    tick();
    chk("uflush_frame_done2", {7'd0, done_w}, 8'd0);
    $display("flush-in-unload sequence checked (checks=%0d failures=%0d)", checks, failures);

    // Async reset while in STAGE2, between clock edges.
    load4(32'h00100000);
    tick();
    rst = 1'b1;
    #1;
    chk("arst_in_ready", {7'd0, if_w.in_ready}, 8'd1);
    chk("arst_out_valid", {7'd0, if_w.out_valid}, 8'd0);
    chk("arst_out_data", if_w.out_data, 8'h00);
    chk("arst_busy", {7'd0, busy_w}, 8'd0);
    chk("arst_frame_done", {7'd0, done_w}, 8'd0);
    #1 rst = 1'b0;
    tick();
    send_frame(32'h10000000);
    unload(32'h10101010, 32'h10101010, -1);
    $display("async-reset sequence checked (checks=%0d failures=%0d)", checks, failures);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
